sma_mem_stage: RTL

Memory-access stage directly downstream of the SMA bounds engine. It accepts the checked address and the overflow/underflow flags, and turns bounds violations, illegal sizes and misalignment into precise faults. Legal accesses become a single aligned 64-bit memory request with byte enables. Load data is aligned and extended, then returned to writeback through a valid/ready handshake.

---
 rtl/sma_pkg.sv | 42 ++++
 rtl/sma_load_align.sv | 26 ++
 rtl/sma_mem_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sma_pkg.sv
// Shared types and constants for the SMA memory-access stage.
package sma_pkg;

    localparam logic [2:0] FAULT_NONE = 3'd0;
    localparam logic [2:0] UNDERFLOW  = 3'd1;
    localparam logic [2:0] OVERFLOW   = 3'd2;
    localparam logic [2:0] MISALIGN   = 3'd3;
    localparam logic [2:0] BAD_SIZE   = 3'd4;

    localparam logic [2:0] AT_B = 3'd0;
    localparam logic [2:0] AT_H = 3'd1;
    localparam logic [2:0] AT_W = 3'd2;
    localparam logic [2:0] AT_D = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } state_t;

    // Byte-lane mask for an access of 2^at bytes starting at lane 0.
    function automatic logic [7:0] lane_mask(input logic [1:0] at);
        case (at)
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] at);
        case (at)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/sma_load_align.sv
// Combinational load-data alignment: shifts the addressed bytes down to lane 0
// and zero/sign-extends them from 8*2^access_type bits.
module sma_load_align #(
    parameter int WORD_WIDTH = 64
) (
    input  logic [WORD_WIDTH-1:0] i_rdata,
    input  logic [2:0]            i_offset,
    input  logic [2:0]            i_access_type,
    input  logic                  i_signed,
    output logic [WORD_WIDTH-1:0] o_data
);

    logic [WORD_WIDTH-1:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        o_data    = w_shifted;
        case (i_access_type)
            3'd0: o_data = {{(WORD_WIDTH-8){i_signed & w_shifted[7]}},   w_shifted[7:0]};
            3'd1: o_data = {{(WORD_WIDTH-16){i_signed & w_shifted[15]}}, w_shifted[15:0]};
            3'd2: o_data = {{(WORD_WIDTH-32){i_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/sma_mem_stage.sv
// Memory-access stage after the SMA bounds engine: faults bad accesses, issues
// one aligned memory request per legal access and returns results to writeback.
module sma_mem_stage
    import sma_pkg::*;
#(
    parameter int WORD_WIDTH = 64,
    parameter int PTR_WIDTH  = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic                  req_signed,
    input  logic [2:0]            access_type,
    input  logic [WORD_WIDTH-1:0] sma_address,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic [WORD_WIDTH-1:0] store_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [PTR_WIDTH-1:0]  mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_be,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_data,
    output logic                  rsp_fault,
    output logic [2:0]            fault_code,
    output logic [WORD_WIDTH-1:0] fault_addr
);

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_store;
    logic                  r_signed;
    logic [2:0]            r_at;
    logic [2:0]            r_off;
    logic                  r_mem_req_valid;
    logic [PTR_WIDTH-1:0]  r_mem_addr;
    logic                  r_mem_we;
    logic [7:0]            r_mem_be;
    logic [WORD_WIDTH-1:0] r_mem_wdata;
    logic                  r_rsp_valid;
    logic [WORD_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_fault;
    logic [2:0]            r_fault_code;
    logic [WORD_WIDTH-1:0] r_fault_addr;

    logic [2:0]            w_fault_code;
    logic [7:0]            w_be;
    logic [WORD_WIDTH-1:0] w_wdata;
    logic [WORD_WIDTH-1:0] w_load_data;

    // Size is judged before alignment so an illegal size never reports misalign.
    always_comb begin
        w_fault_code = FAULT_NONE;
        if (underflow)
            w_fault_code = UNDERFLOW;
        else if (overflow)
            w_fault_code = OVERFLOW;
        else if (access_type > AT_D)
            w_fault_code = BAD_SIZE;
        else if ((sma_address[2:0] & align_mask(access_type[1:0])) != 3'b000)
            w_fault_code = MISALIGN;
    end

    assign w_be    = lane_mask(access_type[1:0]) << sma_address[2:0];
    assign w_wdata = store_data << {sma_address[2:0], 3'b000};

    sma_load_align #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_load_align (
        .i_rdata       (mem_rdata),
        .i_offset      (r_off),
        .i_access_type (r_at),
        .i_signed      (r_signed),
        .o_data        (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b0;
            r_store         <= 1'b0;
            r_signed        <= 1'b0;
            r_at            <= 3'd0;
            r_off           <= 3'd0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_we        <= 1'b0;
            r_mem_be        <= 8'h00;
            r_mem_wdata     <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_fault     <= 1'b0;
            r_fault_code    <= FAULT_NONE;
            r_fault_addr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_store     <= req_store;
                        r_signed    <= req_signed;
                        r_at        <= access_type;
                        r_off       <= sma_address[2:0];
                        if (w_fault_code != FAULT_NONE) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_data   <= '0;
                            r_rsp_fault  <= 1'b1;
                            r_fault_code <= w_fault_code;
                            r_fault_addr <= sma_address;
                            r_state      <= RSP;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= {sma_address[PTR_WIDTH-1:3], 3'b000};
                            r_mem_we        <= req_store;
                            r_mem_be        <= w_be;
                            r_mem_wdata     <= w_wdata;
                            r_state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_addr      <= '0;
                        r_mem_we        <= 1'b0;
                        r_mem_be        <= 8'h00;
                        r_mem_wdata     <= '0;
                        if (r_store) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                            r_state     <= RSP;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_load_data;
                        r_state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_rsp_data   <= '0;
                        r_rsp_fault  <= 1'b0;
                        r_fault_code <= FAULT_NONE;
                        r_fault_addr <= '0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_be        = r_mem_be;
    assign mem_wdata     = r_mem_wdata;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_fault     = r_rsp_fault;
    assign fault_code    = r_fault_code;
    assign fault_addr    = r_fault_addr;

endmodule
